uart_fifo_periph: RTL and testbench

//  CPU-mapped UART peripheral with parametrised TX and RX FIFOs, an 8N1-style serial engine and a

---
 rtl/uart_fifo_periph.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_fifo_periph.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_periph.sv
// CPU-mapped 8N1 UART: TX/RX FIFOs, prescaled baud generator, RX error flags
// and a registered, maskable active-low interrupt.
module uart_fifo_periph #(
    parameter int FIFO_DEPTH = 16,
    parameter int PRESCALE   = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic [1:0] ADDR,
    input  logic       NCS,
    input  logic       NO,
    input  logic       NW,
    inout  logic [7:0] DATA,
    output logic       NINT,
    input  logic       RX,
    output logic       TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PRESCALE) + 9;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          en_q, en_d;
    logic [2:0]    intmask_q, intmask_d;
    logic [7:0]    baud_q, baud_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          nint_q, nint_d;
    logic          rd_sel_q, rd_sel_d;

    logic [AW:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];

    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic          rx_s1_q, rx_s2_q;

    logic          cs_wr, cs_rd, wr_ctrl, wr_mask, wr_data, wr_baud, rd_data_sel;
    logic          tx_full, tx_empty, rx_full, rx_empty, tx_busy, tx_idle;
    logic          tx_push, tx_pop, rx_push, rx_pop, rx_set_ovr, rx_set_ferr;
    logic [CW-1:0] bit_t, bit_last, half_last;
    logic [7:0]    status, rd_data;

    assign cs_wr       = ~NCS & ~NW;
    assign cs_rd       = ~NCS & ~NO;
    assign wr_ctrl     = cs_wr & (ADDR == 2'd0);
    assign wr_mask     = cs_wr & (ADDR == 2'd1);
    assign wr_data     = cs_wr & (ADDR == 2'd2);
    assign wr_baud     = cs_wr & (ADDR == 2'd3);
    assign rd_data_sel = cs_rd & (ADDR == 2'd2);

    assign bit_t     = CW'(PRESCALE) * (CW'(baud_q) + CW'(1));
    assign bit_last  = bit_t - CW'(1);
    assign half_last = (bit_t >> 1) - CW'(1);

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = ((tx_wptr_q - tx_rptr_q) == (AW+1)'(FIFO_DEPTH));
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = ((rx_wptr_q - rx_rptr_q) == (AW+1)'(FIFO_DEPTH));
    assign tx_busy  = (tx_state_q != S_IDLE);
    assign tx_idle  = tx_empty & ~tx_busy;

    assign tx_push = wr_data & en_q & ~tx_full;
    // One pop per read access: fires on the edge where the DATA read select drops.
    assign rx_pop  = rd_sel_q & ~rd_data_sel & ~rx_empty;

    assign status = {tx_busy, rx_ferr_q, rx_ovr_q, rx_full, ~rx_empty, tx_empty, tx_full, en_q};

    always_comb begin
        rd_data = 8'd0;
        case (ADDR)
            2'd0:    rd_data = status;
            2'd1:    rd_data = {5'd0, intmask_q};
            2'd2:    rd_data = rx_empty ? 8'd0 : rx_mem_q[rx_rptr_q[AW-1:0]];
            default: rd_data = baud_q;
        endcase
    end

    assign DATA = cs_rd ? rd_data : 8'hzz;
    assign TX   = tx_line_q;
    assign NINT = nint_q;

    always_comb begin
        en_d      = en_q;
        intmask_d = intmask_q;
        baud_d    = baud_q;
        rx_ovr_d  = rx_ovr_q;
        rx_ferr_d = rx_ferr_q;
        if (wr_ctrl) begin
            en_d = DATA[0];
            if (DATA[5]) rx_ovr_d = 1'b0;
            if (DATA[6]) rx_ferr_d = 1'b0;
        end
        if (wr_mask && en_q) intmask_d = DATA[2:0];
        if (wr_baud && !en_q) baud_d = DATA;
        if (rx_set_ovr) rx_ovr_d = 1'b1;
        if (rx_set_ferr) rx_ferr_d = 1'b1;
        nint_d   = ~(|(intmask_q & {rx_ovr_q | rx_ferr_q, tx_idle, ~rx_empty}) & en_q);
        rd_sel_d = rd_data_sel;
        tx_wptr_d = tx_push ? tx_wptr_q + (AW+1)'(1) : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + (AW+1)'(1) : tx_rptr_q;
        rx_wptr_d = rx_push ? rx_wptr_q + (AW+1)'(1) : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + (AW+1)'(1) : rx_rptr_q;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (!en_q) begin
            tx_state_d = S_IDLE;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_mem_q[tx_rptr_q[AW-1:0]];
                        tx_state_d = S_START;
                    end
                end
                S_START: if (tx_cnt_q == bit_last) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end
                S_DATA: if (tx_cnt_q == bit_last) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = S_STOP;
                    else tx_bit_d = tx_bit_q + 3'd1;
                end
                default: if (tx_cnt_q == bit_last) begin
                    // Back-to-back frames: reload straight into START with no idle gap.
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_mem_q[tx_rptr_q[AW-1:0]];
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            endcase
        end
        case (tx_state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_set_ovr  = 1'b0;
        rx_set_ferr = 1'b0;
        if (!en_q) begin
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_d = '0;
                    if (!rx_s2_q) rx_state_d = S_START;
                end
                S_START: if (rx_cnt_q == half_last) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_cnt_q == bit_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = S_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end
                default: if (rx_cnt_q == bit_last) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q) rx_set_ferr = 1'b1;
                    else if (rx_full) rx_set_ovr = 1'b1;
                    else rx_push = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= DATA;
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= 8'(rx_shift_q);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            en_q       <= 1'b0;
            intmask_q  <= '0;
            baud_q     <= '0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            nint_q     <= 1'b1;
            rd_sel_q   <= 1'b0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
        end else begin
            en_q       <= en_d;
            intmask_q  <= intmask_d;
            baud_q     <= baud_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
            nint_q     <= nint_d;
            rd_sel_q   <= rd_sel_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
        end
    end
endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph: bus tasks, a TX line decoder feeding a
// scoreboard, an RX frame injector and a single summary line.
module tb_uart_fifo_periph;
    logic       CLK = 1'b0;
    logic       NRST;
    logic [1:0] ADDR;
    logic       NCS, NO, NW;
    wire  [7:0] DATA;
    logic       NINT, RX, TX;

    logic [7:0] drv_data;
    logic       drv_oe;
    logic       loop_en;
    logic       rx_drv;
    logic       mon_on;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bit_t = 16;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    int         start_cyc[$];

    assign DATA = drv_oe ? drv_data : 8'hzz;
    assign RX   = loop_en ? TX : rx_drv;

    uart_fifo_periph #(.FIFO_DEPTH(16), .PRESCALE(16), .DATA_BITS(8)) dut (
        .CLK(CLK), .NRST(NRST), .ADDR(ADDR), .NCS(NCS), .NO(NO), .NW(NW),
        .DATA(DATA), .NINT(NINT), .RX(RX), .TX(TX)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR = a; drv_data = d; drv_oe = 1'b1; NCS = 1'b0; NW = 1'b0;
        @(posedge CLK); #1;
        NCS = 1'b1; NW = 1'b1; drv_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge CLK);
        ADDR = a; NCS = 1'b0; NO = 1'b0;
        #1 d = DATA;
        @(posedge CLK); #1;
        NCS = 1'b1; NO = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge CLK);
        rx_drv = 1'b0;
        repeat (bit_t) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (bit_t) @(negedge CLK);
        end
        rx_drv = stop;
        if (stop) begin
            repeat (bit_t) @(negedge CLK);
        end else begin
            repeat ((bit_t * 3) / 4) @(negedge CLK);
            rx_drv = 1'b1;
            repeat (bit_t / 4) @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
    endtask

    // TX line decoder: samples mid-bit and checks against the expected queue.
    initial begin
        logic [7:0] got;
        forever begin
            @(negedge CLK);
            if (mon_on && TX === 1'b0) begin
                start_cyc.push_back(cyc);
                repeat (bit_t / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (bit_t) @(negedge CLK);
                    got[i] = TX;
                end
                checks++;
                assert (tx_exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_extra_frame: observed %0h expected none", got);
                end
                if (tx_exp_q.size() != 0) check("tx_frame", got, tx_exp_q.pop_front());
                repeat (bit_t) @(negedge CLK);
                check("tx_stop_bit", TX, 1);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] b;
        int         wr_cyc, n_busy, bad;
        bit         done;

        NRST = 1'b0; ADDR = 2'd0; NCS = 1'b1; NO = 1'b1; NW = 1'b1;
        drv_data = 8'h00; drv_oe = 1'b0; loop_en = 1'b0; rx_drv = 1'b1; mon_on = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_tx", TX, 1);
        check("rst_nint", NINT, 1);
        bus_read(2'd0, rd);
        check("rst_status", rd, 8'h04);
        @(negedge CLK);
        ADDR = 2'd0; NCS = 1'b0; drv_data = 8'hA0; drv_oe = 1'b1;
        #1 check("bus_hiz_no_read", DATA, 8'hA0);
        NCS = 1'b1; drv_oe = 1'b0;
        @(negedge CLK);
        NRST = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge CLK);

        // Baud timing with T=16
        bus_write(2'd0, 8'h01);
        tx_exp_q.push_back(8'h55);
        start_cyc.delete();
        bus_write(2'd2, 8'h55);
        wr_cyc = cyc;
        n_busy = 0; done = 0;
        ADDR = 2'd0; NCS = 1'b0; NO = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK); #1;
            if (DATA[7]) n_busy++;
            else if (n_busy > 0) done = 1;
        end
        NCS = 1'b1; NO = 1'b1;
        check("tx_busy_cycles", n_busy, 160);
        check("tx_started", start_cyc.size(), 1);
        check("tx_low_latency", (start_cyc.size() > 0) ? ((start_cyc[0] - wr_cyc) <= 2) : 0, 1);
        repeat (4) @(negedge CLK);
        check("tx_q_drained_1", tx_exp_q.size(), 0);

        // Loopback through the RX path
        loop_en = 1'b1;
        tx_exp_q.push_back(8'hA5);
        rx_exp_q.push_back(8'hA5);
        bus_write(2'd2, 8'hA5);
        repeat (10 * 16 + 40) @(negedge CLK);
        bus_read(2'd0, rd);
        check("loop_rx_nempty", rd[3], 1);
        bus_read(2'd2, rd);
        check("loop_rx_data", rd, rx_exp_q.pop_front());
        bus_read(2'd0, rd);
        check("loop_rx_empty_after", rd[3], 0);
        loop_en = 1'b0;

        // TX FIFO full, slower baud, back-to-back frames
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h02);
        bit_t = 48;
        bus_write(2'd0, 8'h01);
        start_cyc.delete();
        for (int i = 0; i < 17; i++) tx_exp_q.push_back(8'(i));
        for (int i = 0; i < 18; i++) bus_write(2'd2, 8'(i));
        bus_read(2'd0, rd);
        check("tx_full", rd[1], 1);
        for (int i = 0; i < 9000 && tx_exp_q.size() != 0; i++) @(negedge CLK);
        repeat (2 * 48) @(negedge CLK);
        bus_read(2'd0, rd);
        check("tx_idle_after_burst", rd[7], 0);
        check("tx_q_drained_burst", tx_exp_q.size(), 0);
        check("tx_frames", start_cyc.size(), 17);
        bad = 0;
        for (int i = 1; i < start_cyc.size(); i++)
            if (start_cyc[i] - start_cyc[i-1] != 10 * 48) bad++;
        check("tx_no_gap", bad, 0);

        // RX overflow and interrupt
        bus_write(2'd0, 8'h00);
        bus_write(2'd3, 8'h00);
        bit_t = 16;
        bus_write(2'd0, 8'h01);
        bus_write(2'd1, 8'h04);
        bus_read(2'd1, rd);
        check("intmask_rd", rd, 8'h04);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        bus_read(2'd0, rd);
        check("rx_full", rd[4], 1);
        check("rx_ovr_before", rd[5], 0);
        check("nint_before_ovr", NINT, 1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        bus_read(2'd0, rd);
        check("rx_ovr_set", rd[5], 1);
        check("nint_on_ovr", NINT, 0);
        bus_write(2'd0, 8'h21);
        @(negedge CLK);
        check("nint_lag", NINT, 0);
        @(negedge CLK);
        check("nint_released", NINT, 1);
        bus_read(2'd0, rd);
        check("rx_ovr_cleared", rd[5], 0);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd2, rd);
            check("rx_data", rd, (rx_exp_q.size() != 0) ? rx_exp_q.pop_front() : 8'hXX);
        end
        bus_read(2'd0, rd);
        check("rx_drained", rd[3], 0);
        bus_read(2'd2, rd);
        check("rx_empty_read", rd, 8'h00);

        // Framing error and write protection
        send_frame(8'h3C, 1'b0);
        repeat (3 * 16) @(negedge CLK);
        bus_read(2'd0, rd);
        check("rx_ferr_set", rd[6], 1);
        check("rx_ferr_no_push", rd[3], 0);
        check("nint_on_ferr", NINT, 0);
        bus_write(2'd0, 8'h41);
        bus_read(2'd0, rd);
        check("rx_ferr_cleared", rd[6], 0);
        bus_write(2'd3, 8'h07);
        bus_read(2'd3, rd);
        check("baud_protected", rd, 8'h00);
        bus_write(2'd0, 8'h00);
        bus_write(2'd1, 8'h03);
        bus_read(2'd1, rd);
        check("intmask_protected", rd, 8'h04);
        check("tx_no_stray_frames", tx_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
